// File: rtl/cal1d_pool_pkg.sv
// Shared definitions for the 1-D pooling accumulator: mode encodings, FSM states
// and the accumulator width derivation.
package cal1d_pool_pkg;

   typedef enum logic [1:0] {
      POOL_SUM = 2'b00,
      POOL_MAX = 2'b01,
      POOL_MIN = 2'b10
   } pool_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } pool_state_e;

   // Headroom of WIN_W bits covers a full-window sum without overflow.
   function automatic int acc_width(input int data_w, input int win_w);
      return data_w + win_w;
   endfunction

endpackage

// File: rtl/cal1d_pool_lane.sv
// One pooling lane: accumulate/compare datapath plus result register.
// CAL1D_POOL_SAT_EN selects saturation instead of wrap when OUT_W < ACC_W.
module cal1d_pool_lane
   import cal1d_pool_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int WIN_W  = 4,
   parameter int OUT_W  = 19
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  pool_mode_e        mode,
   input  logic              first,
   input  logic              acc_ld,
   input  logic              out_ld,
   input  logic [DATA_W-1:0] x,
   output logic [OUT_W-1:0]  out
);

   localparam int ACC_W = acc_width(DATA_W, WIN_W);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] comb;
   logic        [OUT_W-1:0] narrowed;

   assign x_ext = ACC_W'($signed(x));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      comb = x_ext;
      if (!first) begin
         case (mode)
            POOL_MAX: comb = (x_ext > acc) ? x_ext : acc;
            POOL_MIN: comb = (x_ext < acc) ? x_ext : acc;
            default:  comb = acc + x_ext;
         endcase
      end
   end

   generate
      if (OUT_W >= ACC_W) begin : g_ext
         assign narrowed = OUT_W'(comb);
      end else begin : g_narrow
`ifdef CAL1D_POOL_SAT_EN
         // Out of range when the dropped high bits are not all copies of the sign.
         always_comb begin
            narrowed = comb[OUT_W-1:0];
            if (comb[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){comb[ACC_W-1]}})
               narrowed = comb[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
         end
`else
         assign narrowed = comb[OUT_W-1:0];
`endif
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         acc <= '0;
         out <= '0;
      end else begin
         if (acc_ld) acc <= comb;
         if (out_ld) out <= narrowed;
      end
   end

endmodule

// File: rtl/cal1d_pool_accum.sv
// Multi-lane 1-D pooling accumulator (sum/max/min over a configurable window).
// Narrowing behaviour is selected by CAL1D_POOL_SAT_EN in cal1d_pool_lane.
module cal1d_pool_accum
   import cal1d_pool_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int DATA_W  = 16,
   parameter int MAX_WIN = 8,
   parameter int WIN_W   = 4,
   parameter int OUT_W   = 19
) (
   input  logic                    nvdla_core_clk,
   input  logic                    nvdla_core_rst,
   input  logic [1:0]              cfg_mode,
   input  logic [WIN_W-1:0]        cfg_win_len,
   input  logic                    inp_in_pvld,
   output logic                    inp_in_prdy,
   input  logic [LANES*DATA_W-1:0] inp_data,
   output logic                    inp_out_pvld,
   input  logic                    inp_out_prdy,
   output logic [LANES*OUT_W-1:0]  out_data,
   output logic                    pool_busy
);

   pool_state_e      state, state_nxt;
   pool_mode_e       mode_q, mode_cur;
   logic [WIN_W-1:0] cnt, cnt_nxt;
   logic [WIN_W-1:0] len_q, len_eff, len_cur;
   logic             out_vld, out_vld_nxt;
   logic             first, accept, take, last;

   always_comb begin
      len_eff = cfg_win_len;
      if (cfg_win_len == '0)
         len_eff = WIN_W'(1);
      else if (cfg_win_len > WIN_W'(MAX_WIN))
         len_eff = WIN_W'(MAX_WIN);
   end

   // The first beat of a window sees live config; later beats see the latched copy.
   assign first    = (state == ST_IDLE);
   assign mode_cur = first ? pool_mode_e'(cfg_mode) : mode_q;
   assign len_cur  = first ? len_eff : len_q;

   assign inp_in_prdy  = !(out_vld && !inp_out_prdy);
   assign accept       = inp_in_pvld && inp_in_prdy;
   assign take         = out_vld && inp_out_prdy;
   assign last         = accept && (cnt == len_cur - 1'b1);
   assign inp_out_pvld = out_vld;
   assign pool_busy    = (state == ST_ACCUM);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      out_vld_nxt = out_vld;
      if (take) out_vld_nxt = 1'b0;
      if (accept) begin
         if (last) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            out_vld_nxt = 1'b1;
         end else begin
            state_nxt = ST_ACCUM;
            cnt_nxt   = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         out_vld <= 1'b0;
         mode_q  <= POOL_SUM;
         len_q   <= WIN_W'(1);
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         out_vld <= out_vld_nxt;
         if (accept && first) begin
            mode_q <= mode_cur;
            len_q  <= len_eff;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      cal1d_pool_lane #(
         .DATA_W (DATA_W),
         .WIN_W  (WIN_W),
         .OUT_W  (OUT_W)
      ) u_lane (
         .nvdla_core_clk (nvdla_core_clk),
         .nvdla_core_rst (nvdla_core_rst),
         .mode           (mode_cur),
         .first          (first),
         .acc_ld         (accept && !last),
         .out_ld         (last),
         .x              (inp_data[i*DATA_W +: DATA_W]),
         .out            (out_data[i*OUT_W +: OUT_W])
      );
   end

endmodule

// File: tb/tb_cal1d_pool_accum.sv
// Self-checking bench: two instances (OUT_W=19 and OUT_W=16) share stimulus and are
// compared every cycle against a window-level reference model, plus directed cases.
module tb_cal1d_pool_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  cfg_mode = 2'b00;
   logic [3:0]  cfg_win_len = 4'd1;
   logic        inp_in_pvld = 1'b0;
   logic        inp_out_prdy = 1'b1;
   logic [63:0] inp_data = '0;

   logic        prdy19, pvld19, busy19;
   logic        prdy16, pvld16, busy16;
   logic [75:0] out19;
   logic [63:0] out16;

   always #5 clk = ~clk;

   cal1d_pool_accum u_dut19 (
      .nvdla_core_clk (clk),          .nvdla_core_rst (rst),
      .cfg_mode       (cfg_mode),     .cfg_win_len    (cfg_win_len),
      .inp_in_pvld    (inp_in_pvld),  .inp_in_prdy    (prdy19),
      .inp_data       (inp_data),     .inp_out_pvld   (pvld19),
      .inp_out_prdy   (inp_out_prdy), .out_data       (out19),
      .pool_busy      (busy19)
   );

   cal1d_pool_accum #(.OUT_W(16)) u_dut16 (
      .nvdla_core_clk (clk),          .nvdla_core_rst (rst),
      .cfg_mode       (cfg_mode),     .cfg_win_len    (cfg_win_len),
      .inp_in_pvld    (inp_in_pvld),  .inp_in_prdy    (prdy16),
      .inp_data       (inp_data),     .inp_out_pvld   (pvld16),
      .inp_out_prdy   (inp_out_prdy), .out_data       (out16),
      .pool_busy      (busy16)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic signed [127:0] act,
                        input logic signed [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic logic signed [127:0] l19(input int i);
      return $signed(out19[i*19 +: 19]);
   endfunction

   function automatic logic signed [127:0] l16(input int i);
      return $signed(out16[i*16 +: 16]);
   endfunction

   function automatic int eff_len(input int v);
      if (v == 0) return 1;
      if (v > 8) return 8;
      return v;
   endfunction

   function automatic longint nar(input longint v, input int w);
`ifdef CAL1D_POOL_SAT_EN
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (v > hi) v = hi;
      if (v < lo) v = lo;
`endif
      return v;
   endfunction

   // Reference model: collect the beats of a window, then fold them by mode.
   logic [63:0] win_beats [8];
   int          win_cnt = 0;
   int          w_len = 1;
   logic [1:0]  w_mode = 2'b00;
   logic        m_vld = 1'b0;
   logic [75:0] m19 = '0;
   logic [63:0] m16 = '0;
   bit          started = 1'b0;

   always @(posedge clk) begin : model
      logic   m_prdy;
      longint r, x, t;
      started = 1'b1;
      if (rst) begin
         win_cnt = 0;
         m_vld   = 1'b0;
         m19     = '0;
         m16     = '0;
      end else begin
         m_prdy = !(m_vld && !inp_out_prdy);
         if (m_vld && inp_out_prdy) m_vld = 1'b0;
         if (inp_in_pvld && m_prdy) begin
            if (win_cnt == 0) begin
               w_mode = cfg_mode;
               w_len  = eff_len(int'(cfg_win_len));
            end
            win_beats[win_cnt] = inp_data;
            win_cnt++;
            if (win_cnt == w_len) begin
               for (int l = 0; l < 4; l++) begin
                  r = 0;
                  for (int b = 0; b < w_len; b++) begin
                     x = longint'($signed(win_beats[b][l*16 +: 16]));
                     if (b == 0) r = x;
                     else case (w_mode)
                        2'b01:   r = (x > r) ? x : r;
                        2'b10:   r = (x < r) ? x : r;
                        default: r = r + x;
                     endcase
                  end
                  t = nar(r, 19);
                  m19[l*19 +: 19] = t[18:0];
                  t = nar(r, 16);
                  m16[l*16 +: 16] = t[15:0];
               end
               m_vld   = 1'b1;
               win_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("pvld19", pvld19, m_vld);
         check("pvld16", pvld16, m_vld);
         check("prdy19", prdy19, !(m_vld && !inp_out_prdy));
         check("busy19", busy19, win_cnt != 0);
         check("busy16", busy16, win_cnt != 0);
         check("out19", out19, m19);
         check("out16", out16, m16);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a beat until it is accepted; pvld stays high for back-to-back beats.
   task automatic beat(input logic [63:0] d);
      bit ok = 1'b0;
      inp_in_pvld = 1'b1;
      inp_data    = d;
      for (int k = 0; k < 20 && !ok; k++) begin
         ok = prdy19;
         tick();
      end
      if (!ok) check("beat_timeout", 0, 1);
   endtask

   initial begin
      int pulses;
      repeat (3) tick();
      check("rst_pvld", pvld19, 0);
      check("rst_prdy", prdy19, 1);
      check("rst_busy", busy19, 0);
      check("rst_out", out19, 0);
      rst = 1'b0;
      tick();

      // Sum of 1..4 over a 4-beat window.
      cfg_mode = 2'b00; cfg_win_len = 4'd4;
      beat(pk(1, 0, 0, 0));
      check("busy_after_first", busy19, 1);
      beat(pk(2, 0, 0, 0));
      beat(pk(3, 0, 0, 0));
      check("no_early_pvld", pvld19, 0);
      beat(pk(4, 0, 0, 0));
      inp_in_pvld = 1'b0;
      check("sum10", l19(0), 10);
      pulses = int'(pvld19);
      repeat (3) begin tick(); pulses += int'(pvld19); end
      check("one_pulse", pulses, 1);

      // Max then min over -5, 7, -32768 on lane 1.
      cfg_mode = 2'b01; cfg_win_len = 4'd3;
      beat(pk(0, -5, 0, 0)); beat(pk(0, 7, 0, 0)); beat(pk(0, -32768, 0, 0));
      inp_in_pvld = 1'b0;
      check("max7", l19(1), 7);
      tick();
      cfg_mode = 2'b10;
      beat(pk(0, -5, 0, 0)); beat(pk(0, 7, 0, 0)); beat(pk(0, -32768, 0, 0));
      inp_in_pvld = 1'b0;
      check("min19", l19(1), -32768);
      check("min16", l16(1), -32768);
      tick();

      // win_len=1 with output backpressure, then full-throughput resume.
      cfg_mode = 2'b00; cfg_win_len = 4'd1;
      inp_out_prdy = 1'b0;
      beat(pk(100, 0, 0, 0));
      inp_data = pk(200, 0, 0, 0);
      check("stall_prdy", prdy19, 0);
      repeat (3) begin
         tick();
         check("frozen", l19(0), 100);
         check("still_stalled", prdy19, 0);
      end
      inp_out_prdy = 1'b1;
      for (int v = 200; v <= 500; v += 100) begin
         inp_data = pk(v, 0, 0, 0);
         tick();
         check("stream", l19(0), v);
         check("stream_pvld", pvld19, 1);
      end
      inp_in_pvld = 1'b0;
      tick();

      // Mode change mid-window is ignored until the next window.
      cfg_mode = 2'b00; cfg_win_len = 4'd4;
      beat(pk(1, 0, 0, 0)); beat(pk(2, 0, 0, 0));
      cfg_mode = 2'b01;
      beat(pk(3, 0, 0, 0)); beat(pk(4, 0, 0, 0));
      inp_in_pvld = 1'b0;
      check("latched_sum", l19(0), 10);
      beat(pk(1, 0, 0, 0)); beat(pk(5, 0, 0, 0)); beat(pk(2, 0, 0, 0)); beat(pk(3, 0, 0, 0));
      inp_in_pvld = 1'b0;
      check("next_max", l19(0), 5);
      tick();

      // Eight beats of 32767: fits in 19 bits, wraps or saturates in 16.
      cfg_mode = 2'b00; cfg_win_len = 4'd8;
      repeat (8) beat(pk(32767, 0, 0, 0));
      inp_in_pvld = 1'b0;
      check("sum19_big", l19(0), 262136);
`ifdef CAL1D_POOL_SAT_EN
      check("sum16_sat", l16(0), 32767);
`else
      check("sum16_wrap", l16(0), -8);
`endif
      tick();

      // Reset mid-window, then a fresh 2-beat window.
      cfg_win_len = 4'd4;
      beat(pk(1, 0, 0, 0)); beat(pk(1, 0, 0, 0));
      inp_in_pvld = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post_rst_pvld", pvld19, 0);
      check("post_rst_busy", busy19, 0);
      check("post_rst_out", l19(0), 0);
      cfg_win_len = 4'd2;
      beat(pk(3, 0, 0, 0));
      check("no_stale", pvld19, 0);
      beat(pk(3, 0, 0, 0));
      inp_in_pvld = 1'b0;
      check("fresh6", l19(0), 6);
      tick();

      // Randomized traffic with config churn and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] lv [4];
         rst          = ($urandom_range(0, 299) == 0);
         inp_in_pvld  = ($urandom_range(0, 3) != 0);
         inp_out_prdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) cfg_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) cfg_win_len = 4'($urandom_range(0, 15));
         for (int l = 0; l < 4; l++) begin
            case ($urandom_range(0, 7))
               0:       lv[l] = 16'h7fff;
               1:       lv[l] = 16'h8000;
               default: lv[l] = 16'($urandom);
            endcase
         end
         inp_data = {lv[3], lv[2], lv[1], lv[0]};
         tick();
      end
      rst = 1'b0;
      inp_in_pvld = 1'b0;
      inp_out_prdy = 1'b1;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
